// File: rtl/mulberry_div_slave.sv
// ---------------------------------------------------------------------------
// mulberry_pkg
//   Shared mulberry bus identifiers: master IDs (mid_t) carried on request and
//   response tags, and slave IDs (sid_t) used by masters to address a slave.
//
// mulberry_div_slave
//   Sequential restoring unsigned divider sitting on the mulberry bus div_mp
//   modport. A request carries {dividend, divisor}; the response carries
//   {quotient, remainder}, tagged with the requesting master's MID. One
//   quotient bit is produced per clock.
//
//   Ports:
//     clk_ir        in   clock
//     rst_il        in   asynchronous active-low reset
//     div_busy      out  high while dividing or presenting a response
//     div_req_data  in   [P_BUS_DATA_W-1:P_OPND_W] dividend, [P_OPND_W-1:0] divisor
//     div_req_mid   in   requesting master, MID_IDLE = no request
//     div_rsp_data  out  [P_BUS_DATA_W-1:P_OPND_W] quotient, [P_OPND_W-1:0] remainder
//     div_rsp_mid   out  response tag, non-idle for one cycle per result
//
//   P_BUS_DATA_W must be even (and at least 4); operands are half its width.
// ---------------------------------------------------------------------------
package mulberry_pkg;

    typedef enum logic [2:0] {
        MID_IDLE     = 3'd0,
        MID_CPU      = 3'd1,
        MID_GPU_CORE = 3'd2,
        MID_GPU_LB   = 3'd3,
        MID_DMA      = 3'd4
    } mid_t;

    typedef enum logic [1:0] {
        SID_MEM = 2'd0,
        SID_DIV = 2'd1,
        SID_IO  = 2'd2
    } sid_t;

endpackage

module mulberry_div_slave
    import mulberry_pkg::*;
#(
    parameter int P_BUS_DATA_W = 32
) (
    input  logic                    clk_ir,
    input  logic                    rst_il,
    output logic                    div_busy,
    input  logic [P_BUS_DATA_W-1:0] div_req_data,
    input  mid_t                    div_req_mid,
    output logic [P_BUS_DATA_W-1:0] div_rsp_data,
    output mid_t                    div_rsp_mid
);

    localparam int P_OPND_W = P_BUS_DATA_W / 2;
    localparam int CNT_W    = (P_OPND_W > 1) ? $clog2(P_OPND_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // One restoring step. Returns {next_remainder, quotient_bit}.
    // The remainder carries one extra bit so the shifted value never overflows
    // before the compare.
    function automatic logic [P_OPND_W+1:0] div_step(
        input logic [P_OPND_W:0]   rem,
        input logic                msb,
        input logic [P_OPND_W-1:0] dvs
    );
        logic [P_OPND_W:0] shifted;
        logic [P_OPND_W:0] dvs_ext;
        shifted = {rem[P_OPND_W-1:0], msb};
        dvs_ext = {1'b0, dvs};
        if (shifted >= dvs_ext) begin
            div_step = {shifted - dvs_ext, 1'b1};
        end else begin
            div_step = {shifted, 1'b0};
        end
    endfunction

    state_t              state;
    logic [CNT_W-1:0]    iter_cnt;
    // Dividend register doubles as the quotient register: dividend bits shift
    // out of the top while quotient bits shift in at the bottom.
    logic [P_OPND_W-1:0] dvd_q;
    logic [P_OPND_W-1:0] dvs_q;
    logic [P_OPND_W:0]   rem_q;
    mid_t                mid_q;
    logic [P_OPND_W+1:0] step;

    always_comb begin
        step = div_step(rem_q, dvd_q[P_OPND_W-1], dvs_q);
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state        <= ST_IDLE;
            iter_cnt     <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            rem_q        <= '0;
            mid_q        <= MID_IDLE;
            div_busy     <= 1'b0;
            div_rsp_data <= '0;
            div_rsp_mid  <= MID_IDLE;
        end else begin
            // The tag is a single-cycle pulse; data is left holding.
            div_rsp_mid <= MID_IDLE;

            case (state)
                // Accept stage: requests are only looked at here, so anything
                // arriving during CALC/RSP is simply dropped.
                ST_IDLE: begin
                    div_busy <= 1'b0;
                    if (div_req_mid != MID_IDLE) begin
                        dvd_q    <= div_req_data[P_BUS_DATA_W-1:P_OPND_W];
                        dvs_q    <= div_req_data[P_OPND_W-1:0];
                        mid_q    <= div_req_mid;
                        rem_q    <= '0;
                        iter_cnt <= CNT_W'(P_OPND_W - 1);
                        div_busy <= 1'b1;
                        state    <= ST_CALC;
                    end
                end

                // Iteration stage: one quotient bit per cycle. A zero divisor
                // is not special-cased; the compare always succeeds, giving an
                // all-ones quotient and the dividend as remainder.
                ST_CALC: begin
                    div_busy <= 1'b1;
                    dvd_q    <= {dvd_q[P_OPND_W-2:0], step[0]};
                    rem_q    <= step[P_OPND_W+1:1];
                    if (iter_cnt == '0) begin
                        state <= ST_RSP;
                    end else begin
                        iter_cnt <= iter_cnt - 1'b1;
                    end
                end

                // Response stage: busy stays up through the cycle the result
                // is presented, then drops in IDLE unless a new request lands.
                ST_RSP: begin
                    div_busy     <= 1'b1;
                    div_rsp_mid  <= mid_q;
                    div_rsp_data <= {dvd_q, rem_q[P_OPND_W-1:0]};
                    state        <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
